// File: rtl/verde_frame_ctrl.sv
// verde_frame_ctrl: camera byte assembly, pixel strobing and per-frame green statistics.
module verde_frame_ctrl #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int MIN_PIXELS = 64
) (
    input  logic        PCLK,
    input  logic        rst_n,
    input  logic        VSYNC,
    input  logic        HREF,
    input  logic [7:0]  D,
    input  logic        enable,
    input  logic        verde,
    output logic        e_pix,
    output logic [7:0]  Y_o,
    output logic [7:0]  Cb_o,
    output logic [7:0]  Cr_o,
    output logic        frame_done,
    output logic [18:0] green_count,
    output logic [9:0]  x_min,
    output logic [9:0]  x_max,
    output logic [9:0]  y_min,
    output logic [9:0]  y_max,
    output logic        found
);
    typedef enum logic [2:0] {IDLE, WAIT_FRAME, ACTIVE, FLUSH, LATCH} state_t;
    state_t state;
    logic        vsync_q, href_q, v_valid;
    logic [1:0]  phase;
    logic [9:0]  col, line, e_col, e_line, v_col, v_line;
    logic [7:0]  cb_r, y0_r, cr_r;
    logic [18:0] acc_cnt;
    logic [9:0]  ax_min, ax_max, ay_min, ay_max;
    logic        vs_rise, vs_fall, href_fall, slot, emit, hit;
    always_comb begin
        vs_rise   = VSYNC & ~vsync_q;
        vs_fall   = ~VSYNC & vsync_q;
        href_fall = ~HREF & href_q;
        slot      = (state == ACTIVE) && HREF && !VSYNC && phase[1];
        emit      = slot && (col < 10'(H_ACTIVE)) && (line < 10'(V_ACTIVE));
        hit       = v_valid && verde && (state == ACTIVE || state == FLUSH);
    end
    always_ff @(posedge PCLK) begin
        if (!rst_n) begin
            state       <= IDLE;
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            phase       <= '0;
            col         <= '0;
            line        <= '0;
            cb_r        <= '0;
            y0_r        <= '0;
            cr_r        <= '0;
            e_pix       <= 1'b0;
            Y_o         <= '0;
            Cb_o        <= '0;
            Cr_o        <= '0;
            e_col       <= '0;
            e_line      <= '0;
            v_valid     <= 1'b0;
            v_col       <= '0;
            v_line      <= '0;
            acc_cnt     <= '0;
            ax_min      <= '1;
            ax_max      <= '0;
            ay_min      <= '1;
            ay_max      <= '0;
            frame_done  <= 1'b0;
            green_count <= '0;
            x_min       <= '0;
            x_max       <= '0;
            y_min       <= '0;
            y_max       <= '0;
            found       <= 1'b0;
        end else begin
            vsync_q    <= VSYNC;
            href_q     <= HREF;
            frame_done <= 1'b0;
            e_pix      <= emit;
            v_valid    <= e_pix;
            v_col      <= e_col;
            v_line     <= e_line;
            phase      <= (state == ACTIVE && HREF) ? phase + 2'd1 : 2'd0;
            if (state == ACTIVE && HREF) begin
                if (phase == 2'd0) cb_r <= D;
                if (phase == 2'd1) y0_r <= D;
                if (phase == 2'd2) cr_r <= D;
            end
            // phase 2 carries Cr on the bus, phase 3 carries Y1
            if (emit) begin
                Y_o    <= phase[0] ? D : y0_r;
                Cb_o   <= cb_r;
                Cr_o   <= phase[0] ? cr_r : D;
                e_col  <= col;
                e_line <= line;
            end
            if (slot && col < 10'(H_ACTIVE)) col <= col + 10'd1;
            if (state == ACTIVE && href_fall) begin
                col <= '0;
                if (line < 10'(V_ACTIVE)) line <= line + 10'd1;
            end
            if (hit) begin
                acc_cnt <= acc_cnt + {18'd0, ~&acc_cnt};
                ax_min  <= (v_col < ax_min) ? v_col : ax_min;
                ax_max  <= (v_col > ax_max) ? v_col : ax_max;
                ay_min  <= (v_line < ay_min) ? v_line : ay_min;
                ay_max  <= (v_line > ay_max) ? v_line : ay_max;
            end
            case (state)
                IDLE:       if (VSYNC) state <= WAIT_FRAME;
                WAIT_FRAME: if (vs_fall && enable) begin
                    state   <= ACTIVE;
                    col     <= '0;
                    line    <= '0;
                    acc_cnt <= '0;
                    ax_min  <= '1;
                    ax_max  <= '0;
                    ay_min  <= '1;
                    ay_max  <= '0;
                end
                ACTIVE:     if (vs_rise) state <= FLUSH;
                FLUSH:      state <= LATCH;
                LATCH: begin
                    state       <= WAIT_FRAME;
                    frame_done  <= 1'b1;
                    green_count <= acc_cnt;
                    x_min       <= ax_min;
                    x_max       <= ax_max;
                    y_min       <= ay_min;
                    y_max       <= ay_max;
                    found       <= acc_cnt >= 19'(MIN_PIXELS);
                end
                default:    state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_verde_frame_ctrl.sv
// tb_verde_frame_ctrl: randomized frames against a scoreboard of expected pixels and frame results.
module tb_verde_frame_ctrl;
    localparam int H = 8;
    localparam int V = 4;
    localparam int MINP = 4;
    logic PCLK = 0, rst_n = 0, VSYNC = 0, HREF = 0, enable = 0, verde = 0;
    logic [7:0] D = 0;
    logic e_pix, frame_done, found;
    logic [7:0] Y_o, Cb_o, Cr_o;
    logic [18:0] green_count;
    logic [9:0] x_min, x_max, y_min, y_max;
    verde_frame_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .MIN_PIXELS(MINP)) dut (
        .PCLK(PCLK), .rst_n(rst_n), .VSYNC(VSYNC), .HREF(HREF), .D(D), .enable(enable),
        .verde(verde), .e_pix(e_pix), .Y_o(Y_o), .Cb_o(Cb_o), .Cr_o(Cr_o),
        .frame_done(frame_done), .green_count(green_count), .x_min(x_min), .x_max(x_max),
        .y_min(y_min), .y_max(y_max), .found(found));
    always #5 PCLK = ~PCLK;
    typedef struct {logic [7:0] y, cb, cr; logic g;} pix_t;
    typedef struct {int cnt, xmn, xmx, ymn, ymx, fnd;} frm_t;
    pix_t pq[$];
    frm_t fq[$];
    frm_t last, zero_f, mf;
    pix_t mp;
    logic vpend = 0;
    int checks = 0, errors = 0;
    logic [7:0] dir [4] = '{8'h10, 8'h50, 8'h20, 8'h60};
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask
    task automatic check_out(input frm_t f, input string tag);
        chk({tag, ".green_count"}, green_count, f.cnt);
        chk({tag, ".x_min"}, x_min, f.xmn);
        chk({tag, ".x_max"}, x_max, f.xmx);
        chk({tag, ".y_min"}, y_min, f.ymn);
        chk({tag, ".y_max"}, y_max, f.ymx);
        chk({tag, ".found"}, found, f.fnd);
    endtask
    // monitor: pops expected pixels and frame results, plays the detector one cycle later
    initial forever begin
        @(negedge PCLK);
        verde = vpend;
        vpend = 0;
        if (e_pix) begin
            if (pq.size() == 0) chk("unexpected_e_pix", 1, 0);
            else begin
                mp = pq.pop_front();
                chk("Y_o", Y_o, mp.y);
                chk("Cb_o", Cb_o, mp.cb);
                chk("Cr_o", Cr_o, mp.cr);
                vpend = mp.g;
            end
        end
        if (frame_done) begin
            if (fq.size() == 0) chk("unexpected_frame_done", 1, 0);
            else begin
                mf = fq.pop_front();
                check_out(mf, "frame");
            end
        end
    end
    task automatic drive(input logic v, input logic h, input logic [7:0] d);
        VSYNC = v;
        HREF = h;
        D = d;
        @(negedge PCLK);
    endtask
    task automatic frame(input bit en, input int nl, input bit abrupt, input int rst_line, input bit directed);
        int cnt = 0, xmn = 1023, xmx = 0, ymn = 1023, ymx = 0;
        int nb, col, ph;
        logic [7:0] cb = 0, y0 = 0, cr = 0, d;
        pix_t p;
        frm_t f;
        repeat (4) drive(1, 0, 0);
        enable = en;
        drive(0, 0, 0);
        enable = 1'($urandom);
        drive(0, 0, 0);
        for (int l = 0; l < nl; l++) begin
            nb = (directed && l == 0) ? 4 : 4 * $urandom_range(0, 6) + $urandom_range(0, 3);
            if (nb == 0) nb = 1;
            for (int b = 0; b < nb; b++) begin
                d = (directed && l == 0) ? dir[b] : 8'($urandom);
                ph = b % 4;
                if (ph == 0) cb = d;
                if (ph == 1) y0 = d;
                if (ph == 2) cr = d;
                col = 2 * (b / 4) + ph - 2;
                if (ph >= 2 && en && col < H && l < V) begin
                    p.y = (ph == 2) ? y0 : d;
                    p.cb = cb;
                    p.cr = cr;
                    p.g = (cb < 8'h80) && (cr < 8'h80);
                    pq.push_back(p);
                    if (p.g) begin
                        cnt++;
                        xmn = col < xmn ? col : xmn;
                        xmx = col > xmx ? col : xmx;
                        ymn = l < ymn ? l : ymn;
                        ymx = l > ymx ? l : ymx;
                    end
                end
                drive(0, 1, d);
            end
            if (l == rst_line) begin
                drive(0, 0, 0);
                rst_n = 0;
                repeat (3) drive(0, 1, 8'($urandom));
                check_out(zero_f, "midreset");
                chk("midreset.e_pix", e_pix, 0);
                rst_n = 1;
                drive(0, 0, 0);
                last = zero_f;
                return;
            end
            if (!(abrupt && l == nl - 1)) repeat ($urandom_range(1, 3)) drive(0, 0, 0);
        end
        f = '{cnt, xmn, xmx, ymn, ymx, int'(cnt >= MINP)};
        if (en) begin
            fq.push_back(f);
            last = f;
        end
        if (abrupt) drive(1, 1, 8'($urandom));
        drive(1, 0, 0);
    endtask
    initial begin
        zero_f = '{0, 0, 0, 0, 0, 0};
        last = zero_f;
        @(negedge PCLK);
        rst_n = 0;
        repeat (3) drive(0, 1, 8'($urandom));
        check_out(zero_f, "reset");
        chk("reset.e_pix", e_pix, 0);
        chk("reset.frame_done", frame_done, 0);
        rst_n = 1;
        repeat (10) drive(0, 1, 8'($urandom));
        drive(0, 0, 0);
        frame(1, 2, 0, -1, 1);
        for (int i = 0; i < 20; i++) frame(1, $urandom_range(1, 6), 1'($urandom), -1, 0);
        frame(0, 3, 0, -1, 0);
        repeat (6) drive(1, 0, 0);
        check_out(last, "hold");
        frame(1, 4, 0, 1, 0);
        for (int i = 0; i < 6; i++) frame(1, $urandom_range(1, 6), 1'($urandom), -1, 0);
        repeat (8) drive(1, 0, 0);
        chk("pix_queue_empty", pq.size(), 0);
        chk("frame_queue_empty", fq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/verde_frame_ctrl.md
# verde_frame_ctrl

Frame-level sequencer for the green detector. It sits between the camera byte bus (PCLK, VSYNC, HREF, D) and `detectorVerde`. It assembles the 4-byte Cb/Y0/Cr/Y1 groups into per-pixel Y/Cb/Cr words and strobes `e_pix` once per pixel. It tracks pixel coordinates, collects the detector's `verde` result, and reports a per-frame green-pixel count, bounding box and found flag to downstream tracking logic.

## Interface
- H_ACTIVE, 640, active pixels per line; pixels at column ≥ H_ACTIVE are not emitted.
- V_ACTIVE, 480, active lines per frame; lines ≥ V_ACTIVE are not emitted.
- MIN_PIXELS, 64, green-pixel threshold for `found`.
- PCLK  in  1  pixel clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- VSYNC  in  1  high = vertical blank.
- HREF  in  1  high = valid byte on D.
- D  in  8  camera byte, order per group: Cb, Y0, Cr, Y1.
- enable  in  1  sampled at frame start only.
- verde  in  1  detector result, registered, valid the cycle after its `e_pix`.
- e_pix  out  1  one-cycle strobe to detector.
- Y_o, Cb_o, Cr_o  out  8 each  pixel to detector, raw bytes, valid while `e_pix`=1.
- frame_done  out  1  one-cycle pulse when results update.
- green_count  out  19  latched green-pixel count, saturating at 2^19−1.
- x_min, x_max  out  10 each  latched column bounds.
- y_min, y_max  out  10 each  latched line bounds.
- found  out  1  latched: green_count ≥ MIN_PIXELS.

## Operation
- **States:** IDLE, WAIT_FRAME, ACTIVE, FLUSH, LATCH.
  - IDLE: wait for VSYNC=1 → WAIT_FRAME. This discards the partial frame seen after reset.
  - WAIT_FRAME: on a VSYNC falling edge, go to ACTIVE if enable=1; otherwise stay. Accumulators are cleared on entry to ACTIVE.
  - ACTIVE: byte assembly and pixel emission. A VSYNC rising edge → FLUSH.
  - FLUSH: one cycle for the in-flight `verde` to be accumulated → LATCH.
  - LATCH: copy accumulators to the outputs and pulse frame_done → WAIT_FRAME.
- **Byte phase:** a 2-bit counter advances on each cycle with HREF=1 and is forced to 0 while HREF=0.
  - Phase 0 stores Cb; phase 1 stores Y0.
  - Phase 2 (Cr) emits pixel 0: Y0/Cb/Cr.
  - Phase 3 (Y1) emits pixel 1: Y1/Cb/Cr.
  - A group truncated by HREF falling is discarded beyond pixels already emitted.
- **Coordinates:**
  - Column: 10-bit, increments per emitted pixel, cleared on HREF falling. It stops incrementing at H_ACTIVE; no wrap.
  - Line: 10-bit, increments on each HREF falling edge within the frame, cleared at ACTIVE entry. It saturates at V_ACTIVE.
  - `e_pix` is suppressed when column ≥ H_ACTIVE or line ≥ V_ACTIVE.
- **Accumulate:** the column and line of each emitted pixel are delayed one cycle and paired with `verde`. When `verde`=1:
  - count +1 (saturating);
  - x_min/x_max and y_min/y_max updated by compare.
- **Accumulator clear values:** count 0, x_min=y_min=1023, x_max=y_max=0.
- **No green in a frame:** the clear values are latched and found=0.
- **Reset (rst_n=0):** all outputs 0, state IDLE, phase/column/line 0, accumulators at their clear values. Reset mid-frame abandons the frame and produces no frame_done.

## Timing
- Output registers: `e_pix`, Y_o, Cb_o and Cr_o are registered, asserted the cycle after the Cr byte (phase 2) or Y1 byte (phase 3) is sampled.
  - One full group gives two `e_pix` pulses on consecutive cycles.
- Latency: D byte → `e_pix` is 1 cycle; `e_pix` → `verde` is 1 cycle (detector); `verde` → accumulator is 1 cycle.
- Frame end: the VSYNC rising edge is detected in the cycle it is sampled; FLUSH follows 1 cycle later and LATCH 1 cycle after that.
  - frame_done is high for exactly 1 cycle, concurrent with the new output values.
  - `verde` arriving in the cycle of the VSYNC rise or in FLUSH is counted in the closing frame.
- Simultaneous events:
  - HREF falling in the same cycle as a phase-3 emission: the emission completes; column clears the next cycle.
  - VSYNC rise while HREF=1: the group is abandoned and no further `e_pix` is issued.
- Result persistence: latched outputs hold until the next LATCH or reset.

## Test plan
1. Reset held low 3 cycles mid-line with HREF=1 → all outputs 0, no `e_pix`. After release, no frame_done until a full VSYNC high→low→high cycle has occurred.
2. One line with D=0x10,0x50,0x20,0x60 → `e_pix` on 2 consecutive cycles: (Y,Cb,Cr)=(0x50,0x10,0x20) then (0x60,0x10,0x20), at columns 0 and 1.
3. H_ACTIVE=8, V_ACTIVE=4, MIN_PIXELS=4; `verde` driven 1 for columns 2–5 on lines 1–2 → frame_done pulse with green_count=8, x_min=2, x_max=5, y_min=1, y_max=2, found=1.
4. HREF drops after 3 bytes → exactly one `e_pix` (pixel 0). The next line starts at column 0, phase 0.
5. Line of 12 pixels and 6 lines with H_ACTIVE=8, V_ACTIVE=4 → `e_pix` only for columns 0–7 on lines 0–3; 32 strobes per frame.
6. `verde`=1 only for the last pixel, with VSYNC rising the cycle after its `e_pix` → green_count=1, found=0 (MIN_PIXELS=4). Then enable=0 at the next VSYNC fall → no `e_pix` and no frame_done for that frame; outputs hold.
